tile_fetch_requester: RTL and testbench



---
 rtl/tile_fetch_requester.sv | 212 +++++++++++++++++++++
 tb/tb_tile_fetch_requester.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_fetch_requester.sv
// Fetch-command splitter: breaks one command into chunked memory requests, bounds the number in flight and retires them on last beats.
// Optional build macro FETCH_TIMEOUT_EN adds a watchdog and the `timeout` output.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 4
`endif
`ifndef EPOCH_WIDTH
`define EPOCH_WIDTH 4
`endif

package tile_fetch_pkg;
    typedef enum logic [1:0] {
        PRIO_LOW    = 2'd0,
        PRIO_NORM   = 2'd1,
        PRIO_HIGH   = 2'd2,
        PRIO_URGENT = 2'd3
    } req_prio_e;

    typedef enum logic [1:0] {
        REQ_TYPE_DATA     = 2'd0,
        REQ_TYPE_TEX      = 2'd1,
        REQ_TYPE_CONST    = 2'd2,
        REQ_TYPE_PREFETCH = 2'd3
    } req_type_e;

    typedef struct packed {
        logic [`ADDR_WIDTH-1:0]  addr;
        logic [31:0]             len;
        logic [`REQ_ID_WIDTH-1:0] id;
        logic [`EPOCH_WIDTH-1:0] epoch;
        req_type_e               rtype;
        req_prio_e               prio;
    } mem_req_t;

    typedef struct packed {
        logic [`REQ_ID_WIDTH-1:0] id;
        logic [`EPOCH_WIDTH-1:0] epoch;
        logic                    last;
        logic                    error;
    } mem_resp_t;
endpackage

module tile_fetch_requester
    import tile_fetch_pkg::*;
#(
    parameter int MAX_CHUNK_BYTES = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [`ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [31:0]             cmd_len,
    input  req_prio_e               cmd_prio,
    input  logic [`EPOCH_WIDTH-1:0] cmd_epoch,
    output mem_req_t                mem_req,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    input  mem_resp_t               mem_resp,
    input  logic                    mem_resp_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [3:0]              outstanding,
    output logic [15:0]             stale_drop_cnt
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic                    timeout
`endif
);
    localparam int AW = `ADDR_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    if (MAX_CHUNK_BYTES < 1 || (MAX_CHUNK_BYTES & (MAX_CHUNK_BYTES - 1)) != 0) begin : g_bad_chunk
        $error("MAX_CHUNK_BYTES must be a power of two");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_out
        $error("MAX_OUTSTANDING must be 1..15");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
        $error("TIMEOUT_CYCLES must be positive");
    end

    logic [1:0]               state;
    logic [AW-1:0]            cur_addr;
    logic [31:0]              remaining;
    req_prio_e                cur_prio;
    logic [`EPOCH_WIDTH-1:0]  cur_epoch;
    logic [`REQ_ID_WIDTH-1:0] next_id;
    logic [31:0]              chunk_len;
    logic                     issue_hs;
    logic                     resp_match;
    logic                     resp_stale;
    logic                     retire;
    logic                     resp_id_unused;

    // Response ids may return in any order; only the in-flight count is tracked.
    assign resp_id_unused = ^mem_resp.id;

    assign chunk_len = (remaining > 32'(MAX_CHUNK_BYTES)) ? 32'(MAX_CHUNK_BYTES) : remaining;

    // Payload comes straight from state registers, so it cannot move while stalled.
    assign mem_req_valid = (state == ST_ISSUE) && (outstanding < 4'(MAX_OUTSTANDING)) && (remaining != 32'd0);
    assign mem_req = '{addr: cur_addr, len: chunk_len, id: next_id, epoch: cur_epoch,
                       rtype: REQ_TYPE_DATA, prio: cur_prio};

    assign issue_hs   = mem_req_valid && mem_req_ready;
    assign resp_match = mem_resp_valid && (state != ST_IDLE) && (mem_resp.epoch == cur_epoch)
                        && (outstanding != 4'd0);
    assign resp_stale = mem_resp_valid && !resp_match;
    assign retire     = resp_match && mem_resp.last;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_fire;

    assign tmo_fire = (tmo_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (issue_hs || resp_match || outstanding == 4'd0) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cur_addr       <= '0;
            remaining      <= '0;
            cur_prio       <= PRIO_LOW;
            cur_epoch      <= '0;
            next_id        <= '0;
            outstanding    <= '0;
            err            <= 1'b0;
            stale_drop_cnt <= '0;
`ifdef FETCH_TIMEOUT_EN
            timeout        <= 1'b0;
`endif
        end else begin
            if (resp_stale && stale_drop_cnt != 16'hFFFF)
                stale_drop_cnt <= stale_drop_cnt + 16'd1;

            // A simultaneous issue and retire leaves the count unchanged.
            case ({issue_hs, retire})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase

            if (resp_match && mem_resp.error)
                err <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cur_addr  <= cmd_addr;
                        remaining <= cmd_len;
                        cur_prio  <= cmd_prio;
                        cur_epoch <= cmd_epoch;
                        err       <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                        timeout   <= 1'b0;
`endif
                        state     <= (cmd_len == 32'd0) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue_hs) begin
                        cur_addr  <= cur_addr + AW'(chunk_len);
                        remaining <= remaining - chunk_len;
                        next_id   <= next_id + 1'b1;
                        if (remaining == chunk_len)
                            state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (outstanding == 4'd0)
                        state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase

`ifdef FETCH_TIMEOUT_EN
            // Watchdog abandons whatever is still in flight and completes with error.
            if (tmo_fire) begin
                err         <= 1'b1;
                timeout     <= 1'b1;
                outstanding <= '0;
                state       <= ST_DONE;
            end
`endif
        end
    end
endmodule

// File: tb/tb_tile_fetch_requester.sv
// Scoreboard bench for tile_fetch_requester: stimulus queues expected requests/completions, monitors pop and compare.
module tb_tile_fetch_requester;
    import tile_fetch_pkg::*;

    localparam int MAXC = 64;
    localparam int MAXO = 4;
    localparam int TMO  = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr, cmd_len;
    req_prio_e   cmd_prio;
    logic [3:0]  cmd_epoch;
    mem_req_t    mem_req;
    logic        mem_req_valid, mem_req_ready;
    mem_resp_t   mem_resp;
    logic        mem_resp_valid;
    logic        busy, done, err;
    logic [3:0]  outstanding;
    logic [15:0] stale_drop_cnt;
`ifdef FETCH_TIMEOUT_EN
    logic        timeout;
`endif

    always #5 clk = ~clk;

    tile_fetch_requester #(.MAX_CHUNK_BYTES(MAXC), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_prio(cmd_prio), .cmd_epoch(cmd_epoch),
        .mem_req(mem_req), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_resp(mem_resp), .mem_resp_valid(mem_resp_valid),
        .busy(busy), .done(done), .err(err), .outstanding(outstanding), .stale_drop_cnt(stale_drop_cnt)
`ifdef FETCH_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    typedef struct { logic [3:0] id; logic [3:0] epoch; bit err; int beats; int due; } pend_t;
    typedef struct { bit err; bit tmo; bit chk_lat; int hs_gap; } done_t;

    mem_req_t  exp_req_q[$];
    done_t     exp_done_q[$];
    pend_t     pend_q[$];
    mem_resp_t inj_q[$];

    int checks = 0, errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int resp_lat = 3, beats = 1, err_idx = -1, chunk_idx = 0;
    bit resp_silent = 0;
    int last_resp_cyc = 0, last_hs_cyc = 0;
    int max_out = 0;
    logic [3:0] exp_next_id = 4'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Request monitor: payload scoreboard, stall stability, responder feed.
    initial begin
        bit stalled = 0;
        mem_req_t held = '0;
        mem_req_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    chk("req_hold_valid", 128'(mem_req_valid), 128'(1));
                    chk("req_hold_payload", 128'(mem_req), 128'(held));
                end
                stalled = mem_req_valid && !mem_req_ready;
                held = mem_req;
                if (int'(outstanding) > max_out) max_out = int'(outstanding);
                if (mem_req_valid && mem_req_ready) begin
                    if (exp_req_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL req_unexpected: got request addr %0h id %0h, none expected", mem_req.addr, mem_req.id);
                    end else begin
                        e = exp_req_q.pop_front();
                        chk("req_payload", 128'(mem_req), 128'(e));
                    end
                    last_hs_cyc = cyc;
                    if (!resp_silent)
                        pend_q.push_back('{id: mem_req.id, epoch: mem_req.epoch, err: (chunk_idx == err_idx),
                                           beats: beats, due: cyc + resp_lat});
                    chunk_idx++;
                end
            end
        end
    end

    // Completion monitor.
    initial begin
        done_t d;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                done_cnt++;
                if (exp_done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected: got done pulse at cycle %0d, none expected", cyc);
                end else begin
                    d = exp_done_q.pop_front();
                    chk("done_err", 128'(err), 128'(d.err));
`ifdef FETCH_TIMEOUT_EN
                    chk("done_timeout", 128'(timeout), 128'(d.tmo));
`endif
                    chk("done_outstanding", 128'(outstanding), 128'(0));
                    chk("done_all_reqs_issued", 128'(exp_req_q.size()), 128'(0));
                    if (d.chk_lat) chk("done_latency", 128'(cyc), 128'(last_resp_cyc + 2));
                    if (d.hs_gap > 0) chk("timeout_latency", 128'(cyc), 128'(last_hs_cyc + d.hs_gap));
                end
            end
        end
    end

    // Responder: injected beats first, else the oldest due request.
    initial begin
        pend_t p;
        mem_resp_valid = 1'b0;
        mem_resp = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_resp_valid = 1'b0;
            mem_resp = '0;
            if (!rst_n) begin
                pend_q.delete();
                inj_q.delete();
            end else if (inj_q.size() > 0) begin
                mem_resp = inj_q.pop_front();
                mem_resp_valid = 1'b1;
            end else if (pend_q.size() > 0 && cyc >= pend_q[0].due) begin
                p = pend_q[0];
                mem_resp.id = p.id;
                mem_resp.epoch = p.epoch;
                mem_resp.last = (p.beats == 1);
                mem_resp.error = p.err;
                mem_resp_valid = 1'b1;
                if (p.beats == 1) begin
                    void'(pend_q.pop_front());
                    last_resp_cyc = cyc;
                end else begin
                    p.beats--;
                    p.err = 0;
                    pend_q[0] = p;
                end
            end
        end
    end

    task automatic run_cmd(input logic [31:0] addr, input logic [31:0] len, input req_prio_e prio,
                           input logic [3:0] epoch, input bit e_err, input bit e_tmo,
                           input bit chk_lat, input int hs_gap);
        logic [31:0] a = addr, rem = len, c;
        mem_req_t e;
        int n = 0;
        while (rem != 0) begin
            c = (rem > MAXC) ? MAXC : rem;
            e.addr = a; e.len = c; e.id = exp_next_id; e.epoch = epoch;
            e.rtype = REQ_TYPE_DATA; e.prio = prio;
            exp_req_q.push_back(e);
            exp_next_id = exp_next_id + 4'd1;
            a += c; rem -= c;
        end
        exp_done_q.push_back('{err: e_err, tmo: e_tmo, chk_lat: chk_lat, hs_gap: hs_gap});
        @(negedge clk);
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_ready_timeout: got cmd_ready=0 expected 1 within 2000 cycles");
        end
        chunk_idx = 0;
        cmd_addr = addr; cmd_len = len; cmd_prio = prio; cmd_epoch = epoch;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == start) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done expected one within %0d cycles", budget);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_req_t zero_req = '0;
        cmd_valid = 0; cmd_addr = '0; cmd_len = '0; cmd_prio = PRIO_LOW; cmd_epoch = '0;
        mem_req_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_outstanding", 128'(outstanding), 128'(0));
        chk("rst_stale", 128'(stale_drop_cnt), 128'(0));
        chk("rst_req_valid", 128'(mem_req_valid), 128'(0));
        chk("rst_req_payload", 128'(mem_req), 128'(zero_req));
        rst_n = 1'b1;

        // 200 bytes: 64/64/64/8, done two cycles after the last retire beat is driven.
        resp_lat = 6;
        run_cmd(32'h1000, 32'd200, PRIO_HIGH, 4'd3, 0, 0, 1, 0);
        wait_done(300);

        // Zero length: done right after acceptance, no request, idle next cycle.
        run_cmd(32'h2000, 32'd0, PRIO_NORM, 4'd1, 0, 0, 0, 0);
        @(negedge clk);
        chk("zl_done", 128'(done), 128'(1));
        chk("zl_req_valid", 128'(mem_req_valid), 128'(0));
        @(negedge clk);
        chk("zl_busy_after", 128'(busy), 128'(0));
        chk("zl_done_after", 128'(done), 128'(0));

        // 640 bytes with a slow responder and a 5-cycle ready stall.
        resp_lat = 20;
        max_out = 0;
        run_cmd(32'h8000, 32'd640, PRIO_LOW, 4'd5, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 mem_req_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 mem_req_ready = 1'b1;
        wait_done(1000);
        chk("max_outstanding", 128'(max_out), 128'(MAXO));

        // Stale epoch during ISSUE (capped at 4 in flight), then a response in IDLE.
        resp_lat = 60;
        run_cmd(32'h4000, 32'd384, PRIO_NORM, 4'd7, 0, 0, 0, 0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("cap_outstanding", 128'(outstanding), 128'(4));
        chk("cap_req_valid", 128'(mem_req_valid), 128'(0));
        inj_q.push_back('{id: 4'd0, epoch: 4'd8, last: 1'b1, error: 1'b1});
        repeat (3) @(negedge clk);
        chk("stale_issue_cnt", 128'(stale_drop_cnt), 128'(1));
        chk("stale_issue_outstanding", 128'(outstanding), 128'(4));
        chk("stale_issue_err", 128'(err), 128'(0));
        wait_done(1000);
        repeat (3) @(posedge clk);
        inj_q.push_back('{id: 4'd0, epoch: 4'd7, last: 1'b1, error: 1'b0});
        repeat (3) @(negedge clk);
        chk("stale_idle_cnt", 128'(stale_drop_cnt), 128'(2));
        chk("stale_idle_outstanding", 128'(outstanding), 128'(0));

        // Error on a non-last beat of chunk 1; err sticks until the next accept.
        resp_lat = 4; beats = 2; err_idx = 1;
        run_cmd(32'h6000, 32'd128, PRIO_URGENT, 4'd2, 1, 0, 0, 0);
        wait_done(300);
        repeat (4) @(negedge clk);
        chk("err_sticky_idle", 128'(err), 128'(1));
        beats = 1; err_idx = -1;
        run_cmd(32'h6100, 32'd0, PRIO_LOW, 4'd2, 0, 0, 0, 0);
        @(negedge clk);
        chk("err_cleared_on_accept", 128'(err), 128'(0));

`ifdef FETCH_TIMEOUT_EN
        resp_silent = 1;
        run_cmd(32'hA000, 32'd128, PRIO_HIGH, 4'd9, 1, 1, 0, TMO + 2);
        wait_done(400);
        resp_silent = 0;
`endif

        // Reset mid-command abandons everything; ids restart from 0.
        resp_lat = 50;
        run_cmd(32'hC000, 32'd256, PRIO_NORM, 4'd4, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_req_q.delete();
        exp_done_q.delete();
        exp_next_id = 4'd0;
        @(negedge clk);
        chk("midrst_outstanding", 128'(outstanding), 128'(0));
        chk("midrst_busy", 128'(busy), 128'(0));
        rst_n = 1'b1;
        resp_lat = 3;
        run_cmd(32'hD000, 32'd64, PRIO_LOW, 4'd6, 0, 0, 0, 0);
        wait_done(300);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
